ps2_key_cmd_ctrl: RTL and testbench

//  Keyboard front-end controller for the Minesweeper game. It samples the raw PS/2 clock and data

---
 rtl/ps2_ctrl_pkg.sv | 71 +++++++
 rtl/ps2_key_cmd_ctrl_frame_rx.sv | 84 ++++++++
 rtl/ps2_key_cmd_ctrl.sv | 121 ++++++++++++
 tb/tb_ps2_key_cmd_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_ctrl_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard command front-end.
package ps2_ctrl_pkg;

    typedef enum logic [2:0] {
        CmdUp      = 3'd0,
        CmdDown    = 3'd1,
        CmdLeft    = 3'd2,
        CmdRight   = 3'd3,
        CmdReveal  = 3'd4,
        CmdFlag    = 3'd5,
        CmdRestart = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} dec_state_e;

    typedef struct packed {
        logic hit;
        cmd_e cmd;
    } key_hit_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.cmd = CmdUp;
        if (ext) begin
            case (code)
                SC_UP:    r.cmd = CmdUp;
                SC_DOWN:  r.cmd = CmdDown;
                SC_LEFT:  r.cmd = CmdLeft;
                SC_RIGHT: r.cmd = CmdRight;
                SC_ENTER: r.cmd = CmdReveal;
                default:  r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:     r.cmd = CmdUp;
                SC_S:     r.cmd = CmdDown;
                SC_A:     r.cmd = CmdLeft;
                SC_D:     r.cmd = CmdRight;
                SC_SPACE: r.cmd = CmdReveal;
                SC_ENTER: r.cmd = CmdReveal;
                SC_F:     r.cmd = CmdFlag;
                SC_R:     r.cmd = CmdRestart;
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Keyboard status/ack bytes that must not disturb the decoder when idle.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'hFA) || (code == 8'hAA) || (code == 8'hEE) ||
               (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_cmd_ctrl_frame_rx.sv
// PS/2 frame receiver: pin sync, clock glitch filter, 11-bit frame capture and timeout.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN    = 4,
    parameter int unsigned FRAME_TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW  = $clog2(FRAME_TIMEOUT + 1);

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [9:0]      shift_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      byte_q;
    logic            byte_valid_q, frame_err_q;
    logic            filt_flip, fall, timeout, frame_ok;

    assign filt_flip = (clk_sync_q[1] != clk_filt_q) &&
                       (filt_cnt_q == FiltW'(FILTER_LEN - 1));
    assign fall      = filt_flip && clk_filt_q;
    assign timeout   = (bit_cnt_q != 4'd0) && (tmo_q == TmoW'(FRAME_TIMEOUT - 1)) && !fall;
    // shift_q[0] is the start bit, [8:1] data, [9] parity; the stop bit is the live sample.
    assign frame_ok  = !shift_q[0] && (^shift_q[9:1]) && data_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            clk_filt_q   <= 1'b1;
            filt_cnt_q   <= '0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            tmo_q        <= '0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_flip) begin
                filt_cnt_q <= '0;
                clk_filt_q <= ~clk_filt_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q    <= 4'd0;
                    byte_valid_q <= frame_ok;
                    frame_err_q  <= !frame_ok;
                    if (frame_ok) byte_q <= shift_q[8:1];
                end else begin
                    shift_q   <= {data_sync_q[1], shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt_q   <= 4'd0;
                tmo_q       <= '0;
                frame_err_q <= 1'b1;
            end else if (bit_cnt_q != 4'd0) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_cmd_ctrl.sv
// Keyboard front-end: scan-code decoder, held-key tracking and command FIFO.
module ps2_key_cmd_ctrl
    import ps2_ctrl_pkg::*;
#(
    parameter int unsigned FILTER_LEN    = 4,
    parameter int unsigned FRAME_TIMEOUT = 200000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_code,
    output logic       cmd_overflow,
    output logic       frame_err,
    output logic [6:0] held_mask
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [7:0]      rx_byte;
    logic            byte_valid;
    dec_state_e      state_q, state_d;
    logic [6:0]      held_q, held_d;
    logic            resolve, ext, brk, push, pop, full, overflow_q;
    key_hit_t        hit;
    logic [2:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;

    ps2_frame_rx #(
        .FILTER_LEN   (FILTER_LEN),
        .FRAME_TIMEOUT(FRAME_TIMEOUT)
    ) u_frame_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_err) begin
            state_d = StIdle;
        end else if (byte_valid) begin
            unique case (state_q)
                StIdle:   state_d = (rx_byte == SC_EXT) ? StExt :
                                    (rx_byte == SC_BRK) ? StBrk : StIdle;
                StExt:    state_d = (rx_byte == SC_BRK) ? StExtBrk : StIdle;
                StBrk,
                StExtBrk: state_d = (rx_byte == SC_EXT) ? StExt : StIdle;
            endcase
        end
    end

    always_comb begin
        resolve = 1'b0;
        if (byte_valid) begin
            unique case (state_q)
                StIdle:   resolve = (rx_byte != SC_EXT) && (rx_byte != SC_BRK) &&
                                    !is_ignored(rx_byte);
                StExt:    resolve = (rx_byte != SC_BRK);
                StBrk,
                StExtBrk: resolve = (rx_byte != SC_EXT);
            endcase
        end
        ext    = (state_q == StExt) || (state_q == StExtBrk);
        brk    = (state_q == StBrk) || (state_q == StExtBrk);
        hit    = key_lookup(ext, rx_byte);
        held_d = held_q;
        push   = 1'b0;
        // A make for an already-held command is a typematic repeat and is swallowed.
        if (resolve && hit.hit) begin
            if (brk) begin
                held_d[hit.cmd] = 1'b0;
            end else if (!held_q[hit.cmd]) begin
                held_d[hit.cmd] = 1'b1;
                push            = 1'b1;
            end
        end
    end

    assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign cmd_valid = (count_q != '0);
    assign pop       = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q     <= 7'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            overflow_q <= push && full && !pop;
            if (push && (!full || pop)) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !full && !pop)   count_q <= count_q + 1'b1;
            else if (pop && !push)       count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (!full || pop)) fifo_q[wr_ptr_q] <= hit.cmd;
    end

    assign cmd_code     = cmd_valid ? fifo_q[rd_ptr_q] : 3'd0;
    assign cmd_overflow = overflow_q;
    assign held_mask    = held_q;

endmodule

// File: tb/tb_ps2_key_cmd_ctrl.sv
// Directed bench for ps2_key_cmd_ctrl; PS/2 bit period scaled to 40 clk cycles.
module tb_ps2_key_cmd_ctrl;
    localparam int HALF = 20;
    localparam int TMO  = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       cmd_valid, cmd_ready = 1'b1;
    logic [2:0] cmd_code;
    logic       cmd_overflow, frame_err;
    logic [6:0] held_mask;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int err_base;
    logic [2:0] popped[$];

    ps2_key_cmd_ctrl #(
        .FILTER_LEN   (4),
        .FRAME_TIMEOUT(TMO),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_overflow(cmd_overflow),
        .frame_err   (frame_err),
        .held_mask   (held_mask)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_cnt++;
            if (cmd_overflow) ovf_cnt++;
            if (cmd_valid && cmd_ready) popped.push_back(cmd_code);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (i < popped.size()) return {29'd0, popped[i]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
        cyc(2 * HALF);
    endtask

    initial begin
        cyc(3);
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_code", {29'd0, cmd_code}, 32'd0);
        chk("rst_ovf", {31'd0, cmd_overflow}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_held", {25'd0, held_mask}, 32'd0);
        rst_n = 1'b1;
        cyc(10);

        // 1: W make then break
        send(8'h1D);
        chk("t1_held_make", {25'd0, held_mask}, 32'h01);
        send(8'hF0);
        send(8'h1D);
        chk("t1_held_break", {25'd0, held_mask}, 32'h00);
        chk("t1_count", popped.size(), 32'd1);
        chk("t1_cmd", pop_at(0), 32'd0);
        popped.delete();

        // 2: extended Up with typematic repeats
        for (int k = 0; k < 3; k++) begin
            send(8'hE0);
            send(8'h75);
        end
        chk("t2_held_mid", {25'd0, held_mask}, 32'h01);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("t2_count", popped.size(), 32'd1);
        chk("t2_cmd", pop_at(0), 32'd0);
        chk("t2_held_end", {25'd0, held_mask}, 32'h00);
        popped.delete();

        // 3: bad parity then good Space
        err_base = err_cnt;
        send_bits(8'h29, 1'b1, 11);
        cyc(2 * HALF);
        chk("t3_ferr", err_cnt - err_base, 32'd1);
        chk("t3_nocmd", popped.size(), 32'd0);
        chk("t3_held_bad", {25'd0, held_mask}, 32'h00);
        send(8'h29);
        chk("t3_count", popped.size(), 32'd1);
        chk("t3_cmd", pop_at(0), 32'd4);
        chk("t3_held", {25'd0, held_mask}, 32'h10);
        send(8'hF0);
        send(8'h29);
        chk("t3_held_rel", {25'd0, held_mask}, 32'h00);
        popped.delete();

        // 4: fill FIFO, overflow, drain
        cmd_ready = 1'b0;
        send(8'h1D);
        send(8'h1B);
        send(8'h1C);
        send(8'h23);
        chk("t4_ovf_none", ovf_cnt, 32'd0);
        send(8'h29);
        chk("t4_ovf", ovf_cnt, 32'd1);
        chk("t4_held", {25'd0, held_mask}, 32'h1F);
        chk("t4_valid", {31'd0, cmd_valid}, 32'd1);
        chk("t4_head", {29'd0, cmd_code}, 32'd0);
        cmd_ready = 1'b1;
        cyc(10);
        chk("t4_count", popped.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_drain%0d", i), pop_at(i), i);
        chk("t4_empty", {31'd0, cmd_valid}, 32'd0);
        popped.delete();

        // 5: partial frame times out, then R
        err_base = err_cnt;
        send_bits(8'h2D, 1'b0, 5);
        cyc(TMO - 200);
        chk("t5_no_early_tmo", err_cnt - err_base, 32'd0);
        cyc(400);
        chk("t5_tmo", err_cnt - err_base, 32'd1);
        send(8'h2D);
        chk("t5_count", popped.size(), 32'd1);
        chk("t5_cmd", pop_at(0), 32'd6);
        popped.delete();

        // 6: reset mid-frame with a queued command
        cmd_ready = 1'b0;
        send(8'h2B);
        chk("t6_valid_pre", {31'd0, cmd_valid}, 32'd1);
        chk("t6_code_pre", {29'd0, cmd_code}, 32'd5);
        send_bits(8'h1D, 1'b0, 4);
        rst_n = 1'b0;
        cyc(3);
        chk("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("t6_rst_held", {25'd0, held_mask}, 32'd0);
        chk("t6_rst_ovf", {31'd0, cmd_overflow}, 32'd0);
        chk("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        err_base = err_cnt;
        cyc(10);
        send(8'h2B);
        chk("t6_count", popped.size(), 32'd1);
        chk("t6_cmd", pop_at(0), 32'd5);
        chk("t6_no_err", err_cnt - err_base, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
